// File: rtl/gates_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// gates_truth_table_sequencer
//
// Self-test controller for the 2-input / 6-output logic-gates block. On an
// accepted start it walks the four (A,B) combinations 00,01,10,11. For each
// one it drives A/B, waits SETTLE_CYCLES clocks, and then compares the Z bus
// against the hard-coded truth table. When the run ends it pulses done and
// holds a pass/fail summary until the next accepted start.
//
// Parameters
//   SETTLE_CYCLES : clocks between driving A/B and sampling Z (0..255)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   start          in   run request, sampled only while idle
//   gate_a/gate_b  out  registered A/B drive to the gates block
//   gate_z[5:0]    in   Z bus: [0]AND [1]NAND [2]OR [3]NOR [4]XOR [5]XNOR
//   busy           out  high from the cycle after start is accepted to DONE exit
//   done           out  one-cycle end-of-run pulse
//   pass           out  last run had zero mismatching vectors
//   err_count[2:0] out  number of failing vectors in the last run (0..4)
//   err_mask[5:0]  out  OR of (gate_z ^ expected) over the last run
//
// Optional build macro GATES_SEQ_ERRLOG_EN adds:
//   first_err_vec[1:0] out  vector index of the first mismatch of the run
//   first_err_z[5:0]   out  gate_z observed at that first mismatch
// -----------------------------------------------------------------------------
module gates_truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic [5:0] gate_z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [5:0] err_mask
`ifdef GATES_SEQ_ERRLOG_EN
    ,
    output logic [1:0] first_err_vec,
    output logic [5:0] first_err_z
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // The settle counter is loaded with N-1 and exits on zero, so SETTLE
    // lasts exactly N cycles. With N=0 the SETTLE state is skipped.
    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 32'd0) ? 8'd0 :
                                         8'(SETTLE_CYCLES - 32'd1);

    // Golden Z bus for each {A,B} combination.
    function automatic logic [5:0] expected_z(input logic [1:0] vec);
        logic [5:0] z;
        case (vec)
            2'b00:   z = 6'h2A;
            2'b01:   z = 6'h16;
            2'b10:   z = 6'h16;
            2'b11:   z = 6'h25;
            default: z = 6'h00;
        endcase
        return z;
    endfunction

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gate_a_q, gate_a_d;
    logic       gate_b_q, gate_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_count_q, err_count_d;
    logic [5:0] err_mask_q, err_mask_d;
    logic [5:0] diff_s;
    logic       mismatch_s;
`ifdef GATES_SEQ_ERRLOG_EN
    logic [1:0] first_err_vec_q, first_err_vec_d;
    logic [5:0] first_err_z_q, first_err_z_d;
`endif

    assign diff_s     = gate_z ^ expected_z(vec_q);
    assign mismatch_s = |diff_s;

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        gate_a_d    = gate_a_q;
        gate_b_d    = gate_b_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
`ifdef GATES_SEQ_ERRLOG_EN
        first_err_vec_d = first_err_vec_q;
        first_err_z_d   = first_err_z_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_APPLY;
                    vec_d       = 2'd0;
                    pass_d      = 1'b0;
                    err_count_d = 3'd0;
                    err_mask_d  = 6'd0;
`ifdef GATES_SEQ_ERRLOG_EN
                    first_err_vec_d = 2'd0;
                    first_err_z_d   = 6'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                gate_a_d = vec_q[1];
                gate_b_d = vec_q[0];
                if (SETTLE_CYCLES == 32'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_count_d = err_count_q + 3'd1;
                    err_mask_d  = err_mask_q | diff_s;
`ifdef GATES_SEQ_ERRLOG_EN
                    // A zero error count means this is the run's first mismatch.
                    if (err_count_q == 3'd0) begin
                        first_err_vec_d = vec_q;
                        first_err_z_d   = gate_z;
                    end else begin
                        first_err_vec_d = first_err_vec_q;
                    end
`endif
                end else begin
                    err_count_d = err_count_q;
                end
                if (vec_q == 2'd3) begin
                    state_d = ST_DONE;
                    // Uses the updated count so the last vector is included
                    // and pass is already valid while done is high.
                    pass_d  = (err_count_d == 3'd0);
                end else begin
                    state_d = ST_APPLY;
                    vec_d   = vec_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= 8'd0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 3'd0;
            err_mask_q  <= 6'd0;
`ifdef GATES_SEQ_ERRLOG_EN
            first_err_vec_q <= 2'd0;
            first_err_z_q   <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            gate_a_q    <= gate_a_d;
            gate_b_q    <= gate_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
`ifdef GATES_SEQ_ERRLOG_EN
            first_err_vec_q <= first_err_vec_d;
            first_err_z_q   <= first_err_z_d;
`endif
        end
    end

    assign gate_a    = gate_a_q;
    assign gate_b    = gate_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_mask  = err_mask_q;
`ifdef GATES_SEQ_ERRLOG_EN
    assign first_err_vec = first_err_vec_q;
    assign first_err_z   = first_err_z_q;
`endif

endmodule

// File: tb/tb_gates_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gates_truth_table_sequencer
//
// Two sequencers (SETTLE_CYCLES=2 and 0) each drive a behavioural gates block
// with injectable stuck-at-0 / stuck-at-1 masks. A reference model derives
// the expected per-cycle outputs from the gate definitions and the fault
// masks, and the bench compares them cycle by cycle through whole runs.
// -----------------------------------------------------------------------------
module tb_gates_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v;
    logic [1:0] start_v;
    logic [1:0] ga_v;
    logic [1:0] gb_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [1:0] pass_v;
    logic [5:0] gz  [2];
    logic [2:0] ec  [2];
    logic [5:0] em  [2];
    logic [5:0] sa0 [2];
    logic [5:0] sa1 [2];
`ifdef GATES_SEQ_ERRLOG_EN
    logic [1:0] fev [2];
    logic [5:0] fez [2];
`endif

    int tests = 0;
    int fails = 0;

    // Ideal gates block: [0]AND [1]NAND [2]OR [3]NOR [4]XOR [5]XNOR.
    function automatic logic [5:0] ideal(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
    endfunction

    assign gz[0] = (ideal(ga_v[0], gb_v[0]) & ~sa0[0]) | sa1[0];
    assign gz[1] = (ideal(ga_v[1], gb_v[1]) & ~sa0[1]) | sa1[1];

    gates_truth_table_sequencer dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
        .gate_a(ga_v[0]), .gate_b(gb_v[0]), .gate_z(gz[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(ec[0]), .err_mask(em[0])
`ifdef GATES_SEQ_ERRLOG_EN
        , .first_err_vec(fev[0]), .first_err_z(fez[0])
`endif
    );

    gates_truth_table_sequencer #(.SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
        .gate_a(ga_v[1]), .gate_b(gb_v[1]), .gate_z(gz[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(ec[1]), .err_mask(em[1])
`ifdef GATES_SEQ_ERRLOG_EN
        , .first_err_vec(fev[1]), .first_err_z(fez[1])
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, " busy"}, 32'(busy_v[i]), 0);
        chk({tag, " done"}, 32'(done_v[i]), 0);
        chk({tag, " pass"}, 32'(pass_v[i]), 0);
        chk({tag, " err_count"}, 32'(ec[i]), 0);
        chk({tag, " err_mask"}, 32'(em[i]), 0);
        chk({tag, " gate_ab"}, 32'({ga_v[i], gb_v[i]}), 0);
`ifdef GATES_SEQ_ERRLOG_EN
        chk({tag, " first_err_vec"}, 32'(fev[i]), 0);
        chk({tag, " first_err_z"}, 32'(fez[i]), 0);
`endif
    endtask

    task automatic wait_idle(input int i);
        int guard;
        guard = 0;
        while (busy_v[i] !== 1'b0 && guard < 200) begin
            step();
            guard++;
        end
        chk("wait_idle busy", 32'(busy_v[i]), 0);
    endtask

    // One complete run on sequencer i with fault masks f0 (stuck-at-0) and
    // f1 (stuck-at-1). hold keeps start high throughout; repulse adds an
    // extra start pulse mid-run.
    task automatic do_run(input int i, input logic [5:0] f0, input logic [5:0] f1,
                          input bit hold, input bit repulse);
        int s, n, k, ev, fv;
        int cnt_cum [5];
        logic [5:0] mask_cum [5];
        logic [5:0] z, d, fz;
        logic [1:0] vv;
        string t;
        s  = (i == 0) ? 2 : 0;
        n  = 4 * (2 + s) + 1;
        fv = 4;
        fz = 6'd0;
        sa0[i] = f0;
        sa1[i] = f1;
        cnt_cum[0]  = 0;
        mask_cum[0] = 6'd0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            z  = (ideal(vv[1], vv[0]) & ~f0) | f1;
            d  = z ^ ideal(vv[1], vv[0]);
            cnt_cum[v + 1]  = cnt_cum[v] + ((d != 6'd0) ? 1 : 0);
            mask_cum[v + 1] = mask_cum[v] | d;
            if (d != 6'd0 && fv == 4) begin
                fv = v;
                fz = z;
            end
        end
        chk("pre-run idle busy", 32'(busy_v[i]), 0);
        start_v[i] = 1'b1;
        for (int c = 1; c <= n + 1; c++) begin
            if (c > 1) start_v[i] = hold | (repulse && c == 4);
            step();
            t = $sformatf("dut%0d f0=%0h f1=%0h c%0d", i, f0, f1, c);
            k = (c - 1) / (2 + s);
            if (k > 4) k = 4;
            chk({t, " busy"}, 32'(busy_v[i]), (c <= n) ? 1 : 0);
            chk({t, " done"}, 32'(done_v[i]), (c == n) ? 1 : 0);
            chk({t, " pass"}, 32'(pass_v[i]), (c >= n && cnt_cum[4] == 0) ? 1 : 0);
            chk({t, " err_count"}, 32'(ec[i]), cnt_cum[k]);
            chk({t, " err_mask"}, 32'(em[i]), 32'(mask_cum[k]));
            if (c >= 2) begin
                ev = (c - 2) / (2 + s);
                if (ev > 3) ev = 3;
                chk({t, " gate_ab"}, 32'({ga_v[i], gb_v[i]}), ev);
            end
`ifdef GATES_SEQ_ERRLOG_EN
            chk({t, " first_err_vec"}, 32'(fev[i]), (fv < k) ? fv : 0);
            chk({t, " first_err_z"}, 32'(fez[i]), (fv < k) ? 32'(fz) : 0);
`endif
        end
        if (hold) begin
            step();
            chk("hold retrigger busy", 32'(busy_v[i]), 1);
            chk("hold retrigger cleared err_count", 32'(ec[i]), 0);
            chk("hold retrigger cleared pass", 32'(pass_v[i]), 0);
            start_v[i] = 1'b0;
            wait_idle(i);
        end
    endtask

    initial begin
        int i, mode;
        bit saw_done;
        logic [5:0] f0, f1;
        rst_v   = 2'b11;
        start_v = 2'b00;
        sa0[0] = 6'd0; sa0[1] = 6'd0;
        sa1[0] = 6'd0; sa1[1] = 6'd0;
        repeat (3) step();
        chk_zero(0, "reset dut0");
        chk_zero(1, "reset dut1");
        rst_v = 2'b00;
        step();

        // Directed runs: good block, XOR stuck-at-0, AND stuck-at-1,
        // extra start pulses while busy and start held through DONE.
        do_run(0, 6'h00, 6'h00, 1'b0, 1'b0);
        do_run(0, 6'h10, 6'h00, 1'b0, 1'b0);
        do_run(1, 6'h00, 6'h00, 1'b0, 1'b0);
        do_run(1, 6'h10, 6'h00, 1'b0, 1'b0);
        do_run(0, 6'h00, 6'h00, 1'b0, 1'b1);
        do_run(0, 6'h00, 6'h01, 1'b1, 1'b1);
        do_run(1, 6'h00, 6'h01, 1'b1, 1'b0);

        // Reset in cycle 6 of a run aborts it without a done pulse.
        sa0[0] = 6'h00;
        sa1[0] = 6'h01;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        repeat (5) step();
        chk("abort pre-reset err_count", 32'(ec[0]), 1);
        chk("abort pre-reset busy", 32'(busy_v[0]), 1);
        rst_v[0] = 1'b1;
        step();
        chk_zero(0, "abort");
        rst_v[0] = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            step();
            if (done_v[0] !== 1'b0) saw_done = 1'b1;
        end
        chk("abort no done", 32'(saw_done), 0);
        chk("abort stays idle", 32'(busy_v[0]), 0);
        do_run(0, 6'h00, 6'h00, 1'b0, 1'b0);

        // Randomised fault patterns and start behaviour.
        for (int r = 0; r < 16; r++) begin
            i    = r % 2;
            mode = int'($urandom_range(0, 3));
            f0   = 6'd0;
            f1   = 6'd0;
            case (mode)
                1: f0 = 6'(1 << $urandom_range(0, 5));
                2: f1 = 6'(1 << $urandom_range(0, 5));
                3: begin
                    f0 = 6'($urandom);
                    f1 = 6'($urandom);
                end
                default: f0 = 6'd0;
            endcase
            do_run(i, f0, f1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
